rcv_fifo_ptr_ctrl: RTL and testbench

Parametrised head/tail pointer controller for the receive-side FIFO buffers. It generalises the single fixed-depth tail counter to a complete pointer pair of any depth, with wrap-toggle bits, full/empty/almost flags, occupancy count, synchronous flush and sticky overflow/underflow errors. It sits between the receive write logic (push side) and the packet reader (pop side) and drives the RAM write and read addresses directly.

---
 rtl/rcv_fifo_ptr_ctrl_if.sv | 39 +++
 rtl/rcv_fifo_ptr_ctrl.sv | 113 +++++++++++
 tb/tb_rcv_fifo_ptr_ctrl.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/rcv_fifo_ptr_ctrl_if.sv
// Push/pop request and pointer/status bundle between the receive FIFO users and its pointer controller.
// Latency: none; this is wiring only.
// Backpressure: carried by wr_ok/rd_ok, which the controller drives back to the requesters.
interface rcv_fifo_ptr_ctrl_if #(
    parameter int DEPTH = 4
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic             push;
    logic             pop;
    logic             flush;
    logic             err_clr;
    logic [PTR_W-1:0] tail_ptr;
    logic [PTR_W-1:0] head_ptr;
    logic             tail_tog;
    logic             head_tog;
    logic             wr_ok;
    logic             rd_ok;
    logic             full;
    logic             empty;
    logic             almost_full;
    logic             almost_empty;
    logic [CNT_W-1:0] count;
    logic             overflow;
    logic             underflow;

    modport master (
        output push, pop, flush, err_clr,
        input  tail_ptr, head_ptr, tail_tog, head_tog, wr_ok, rd_ok,
        input  full, empty, almost_full, almost_empty, count, overflow, underflow
    );

    modport slave (
        input  push, pop, flush, err_clr,
        output tail_ptr, head_ptr, tail_tog, head_tog, wr_ok, rd_ok,
        output full, empty, almost_full, almost_empty, count, overflow, underflow
    );
endinterface

// File: rtl/rcv_fifo_ptr_ctrl.sv
// Head/tail pointer pair with wrap toggles, occupancy flags and sticky errors for the receive FIFO.
// Latency: wr_ok/rd_ok same cycle as the request; pointers, flags and count update one cycle later.
// Backpressure: a push is refused when full unless a pop frees a slot in the same cycle; a pop is refused when empty.
module rcv_fifo_ptr_ctrl #(
    parameter int DEPTH    = 4,
    parameter int AF_LEVEL = DEPTH - 1,
    parameter int AE_LEVEL = 1
) (
    input  logic                clk,
    input  logic                rst,
    rcv_fifo_ptr_ctrl_if.slave  bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(DEPTH - 1);

    logic [PTR_W-1:0] tail_ptr_q, tail_ptr_d;
    logic [PTR_W-1:0] head_ptr_q, head_ptr_d;
    logic             tail_tog_q, tail_tog_d;
    logic             head_tog_q, head_tog_d;
    logic             overflow_q, overflow_d;
    logic             underflow_q, underflow_d;

    logic             empty_w;
    logic             full_w;
    logic [CNT_W-1:0] count_w;
    logic             wr_ok_w;
    logic             rd_ok_w;

    // Decode status from registered state only, then qualify the requests against it.
    always_comb begin
        empty_w = (head_ptr_q == tail_ptr_q) && (head_tog_q == tail_tog_q);
        full_w  = (head_ptr_q == tail_ptr_q) && (head_tog_q != tail_tog_q);
        if (head_tog_q == tail_tog_q) begin
            count_w = CNT_W'(tail_ptr_q) - CNT_W'(head_ptr_q);
        end else begin
            count_w = CNT_W'(DEPTH) - CNT_W'(head_ptr_q) + CNT_W'(tail_ptr_q);
        end
        // A pop in the same cycle frees the slot a full FIFO needs for the push.
        wr_ok_w = bus.push && (!full_w || bus.pop) && !bus.flush && !rst;
        rd_ok_w = bus.pop && !empty_w && !bus.flush && !rst;
    end

    // Next pointer/toggle values; the wrap at DEPTH-1 flips the toggle instead of rolling over in binary.
    always_comb begin
        tail_ptr_d = tail_ptr_q;
        tail_tog_d = tail_tog_q;
        head_ptr_d = head_ptr_q;
        head_tog_d = head_tog_q;
        if (bus.flush) begin
            tail_ptr_d = '0;
            tail_tog_d = 1'b0;
            head_ptr_d = '0;
            head_tog_d = 1'b0;
        end else begin
            if (wr_ok_w) begin
                if (tail_ptr_q == LAST_IDX) begin
                    tail_ptr_d = '0;
                    tail_tog_d = ~tail_tog_q;
                end else begin
                    tail_ptr_d = tail_ptr_q + PTR_W'(1);
                end
            end
            if (rd_ok_w) begin
                if (head_ptr_q == LAST_IDX) begin
                    head_ptr_d = '0;
                    head_tog_d = ~head_tog_q;
                end else begin
                    head_ptr_d = head_ptr_q + PTR_W'(1);
                end
            end
        end
    end

    // Sticky error flags: a refused request sets, err_clr clears, and a set in the same cycle wins.
    always_comb begin
        overflow_d  = (overflow_q && !bus.err_clr) || (bus.push && !wr_ok_w && !bus.flush);
        underflow_d = (underflow_q && !bus.err_clr) || (bus.pop && !rd_ok_w && !bus.flush);
    end

    // State registers; reset discards all contents immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tail_ptr_q  <= '0;
            tail_tog_q  <= 1'b0;
            head_ptr_q  <= '0;
            head_tog_q  <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            tail_ptr_q  <= tail_ptr_d;
            tail_tog_q  <= tail_tog_d;
            head_ptr_q  <= head_ptr_d;
            head_tog_q  <= head_tog_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign bus.tail_ptr     = tail_ptr_q;
    assign bus.head_ptr     = head_ptr_q;
    assign bus.tail_tog     = tail_tog_q;
    assign bus.head_tog     = head_tog_q;
    assign bus.wr_ok        = wr_ok_w;
    assign bus.rd_ok        = rd_ok_w;
    assign bus.full         = full_w;
    assign bus.empty        = empty_w;
    assign bus.almost_full  = (32'(count_w) >= AF_LEVEL);
    assign bus.almost_empty = (32'(count_w) <= AE_LEVEL);
    assign bus.count        = count_w;
    assign bus.overflow     = overflow_q;
    assign bus.underflow    = underflow_q;
endmodule

// File: tb/tb_rcv_fifo_ptr_ctrl.sv
// Directed vector table on a DEPTH=3 controller plus a random sweep on DEPTH=5 and DEPTH=4 copies.
// Latency: acceptance sampled 2 time units after the inputs change, state 1 unit after the edge.
// Backpressure: the sweep model refuses pushes when full (without pop) and pops when empty.
module tb_rcv_fifo_ptr_ctrl;
    logic clk;
    logic rst;

    rcv_fifo_ptr_ctrl_if #(.DEPTH(3)) if3 ();
    rcv_fifo_ptr_ctrl_if #(.DEPTH(5)) if5 ();
    rcv_fifo_ptr_ctrl_if #(.DEPTH(4)) if4 ();

    rcv_fifo_ptr_ctrl #(.DEPTH(3)) u_dut3 (.clk(clk), .rst(rst), .bus(if3));
    rcv_fifo_ptr_ctrl #(.DEPTH(5), .AF_LEVEL(4), .AE_LEVEL(1)) u_dut5 (.clk(clk), .rst(rst), .bus(if5));
    rcv_fifo_ptr_ctrl #(.DEPTH(4), .AF_LEVEL(4), .AE_LEVEL(1)) u_dut4 (.clk(clk), .rst(rst), .bus(if4));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    typedef struct {
        logic push, pop, flush, err_clr;
        logic wr, rd;
        int   tp, tt, hp, ht, cnt;
        logic full, empty, af, ae, ovf, unf;
    } vec_t;

    vec_t vecs [20];

    task automatic check_state3(input string tag, input vec_t v);
        chk({tag, " tail_ptr"}, int'(if3.tail_ptr), v.tp);
        chk({tag, " tail_tog"}, int'(if3.tail_tog), v.tt);
        chk({tag, " head_ptr"}, int'(if3.head_ptr), v.hp);
        chk({tag, " head_tog"}, int'(if3.head_tog), v.ht);
        chk({tag, " count"}, int'(if3.count), v.cnt);
        chk({tag, " full"}, int'(if3.full), int'(v.full));
        chk({tag, " empty"}, int'(if3.empty), int'(v.empty));
        chk({tag, " almost_full"}, int'(if3.almost_full), int'(v.af));
        chk({tag, " almost_empty"}, int'(if3.almost_empty), int'(v.ae));
        chk({tag, " overflow"}, int'(if3.overflow), int'(v.ovf));
        chk({tag, " underflow"}, int'(if3.underflow), int'(v.unf));
    endtask

    task automatic check_reset_vals(input string tag);
        vec_t z;
        z = '{0,0,0,0, 0,0, 0,0,0,0,0, 0,1,0,1, 0,0};
        check_state3(tag, z);
        chk({tag, " wr_ok"}, int'(if3.wr_ok), 0);
        chk({tag, " rd_ok"}, int'(if3.rd_ok), 0);
    endtask

    task automatic drive3(input logic p, input logic o, input logic f, input logic c);
        if3.push = p; if3.pop = o; if3.flush = f; if3.err_clr = c;
    endtask

    // Sweep models
    int m5_cnt, m5_tp, m5_hp, m4_cnt, m4_tp, m4_hp;

    task automatic sweep_one(input string tag, input int d, input logic p, input logic o,
                             input int wr_act, input int rd_act,
                             inout int mc, inout int mtp, inout int mhp);
        logic ew, er;
        ew = p && ((mc < d) || o);
        er = o && (mc > 0);
        chk({tag, " wr_ok"}, wr_act, int'(ew));
        chk({tag, " rd_ok"}, rd_act, int'(er));
        if (ew) begin mtp = (mtp + 1) % d; mc++; end
        if (er) begin mhp = (mhp + 1) % d; mc--; end
    endtask

    initial begin
        rst = 1'b1;
        drive3(1'b1, 1'b0, 1'b0, 1'b0);
        if5.push = 0; if5.pop = 0; if5.flush = 0; if5.err_clr = 0;
        if4.push = 0; if4.pop = 0; if4.flush = 0; if4.err_clr = 0;

        //            p o f c  wr rd  tp tt hp ht cnt full emp af ae ovf unf
        vecs[0]  = '{1,0,0,0, 1,0,  1,0,0,0,1, 0,0,0,1, 0,0};
        vecs[1]  = '{1,0,0,0, 1,0,  2,0,0,0,2, 0,0,1,0, 0,0};
        vecs[2]  = '{1,0,0,0, 1,0,  0,1,0,0,3, 1,0,1,0, 0,0};
        vecs[3]  = '{1,0,0,0, 0,0,  0,1,0,0,3, 1,0,1,0, 1,0};
        vecs[4]  = '{1,1,0,0, 1,1,  1,1,1,0,3, 1,0,1,0, 1,0};
        vecs[5]  = '{0,0,0,1, 0,0,  1,1,1,0,3, 1,0,1,0, 0,0};
        vecs[6]  = '{0,1,0,0, 0,1,  1,1,2,0,2, 0,0,1,0, 0,0};
        vecs[7]  = '{0,1,0,0, 0,1,  1,1,0,1,1, 0,0,0,1, 0,0};
        vecs[8]  = '{0,1,0,0, 0,1,  1,1,1,1,0, 0,1,0,1, 0,0};
        vecs[9]  = '{0,1,0,0, 0,0,  1,1,1,1,0, 0,1,0,1, 0,1};
        vecs[10] = '{0,1,0,1, 0,0,  1,1,1,1,0, 0,1,0,1, 0,1};
        vecs[11] = '{0,0,0,1, 0,0,  1,1,1,1,0, 0,1,0,1, 0,0};
        vecs[12] = '{1,1,0,0, 1,0,  2,1,1,1,1, 0,0,0,1, 0,1};
        vecs[13] = '{0,0,0,1, 0,0,  2,1,1,1,1, 0,0,0,1, 0,0};
        vecs[14] = '{1,0,0,0, 1,0,  0,0,1,1,2, 0,0,1,0, 0,0};
        vecs[15] = '{1,0,1,0, 0,0,  0,0,0,0,0, 0,1,0,1, 0,0};
        vecs[16] = '{0,1,0,0, 0,0,  0,0,0,0,0, 0,1,0,1, 0,1};
        vecs[17] = '{0,1,1,0, 0,0,  0,0,0,0,0, 0,1,0,1, 0,1};
        vecs[18] = '{1,0,0,0, 1,0,  1,0,0,0,1, 0,0,0,1, 0,1};
        vecs[19] = '{1,0,0,0, 1,0,  2,0,0,0,2, 0,0,1,0, 0,1};

        // Reset state, with a push request held to prove wr_ok is masked.
        #3;
        check_reset_vals("reset");
        @(posedge clk); #1;
        check_reset_vals("reset_held");
        drive3(1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;

        // Directed vector table on DEPTH=3.
        for (int i = 0; i < 20; i++) begin
            string tag;
            tag = $sformatf("vec%0d", i);
            drive3(vecs[i].push, vecs[i].pop, vecs[i].flush, vecs[i].err_clr);
            #2;
            chk({tag, " wr_ok"}, int'(if3.wr_ok), int'(vecs[i].wr));
            chk({tag, " rd_ok"}, int'(if3.rd_ok), int'(vecs[i].rd));
            @(posedge clk); #1;
            check_state3(tag, vecs[i]);
        end

        // Asynchronous reset between edges with count=2 and a push pending.
        drive3(1'b1, 1'b0, 1'b0, 1'b0);
        #2;
        chk("pre_rst wr_ok", int'(if3.wr_ok), 1);
        rst = 1'b1;
        #1;
        check_reset_vals("async_rst");
        @(posedge clk); #1;
        check_reset_vals("async_rst_held");
        drive3(1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        check_reset_vals("after_rst");

        // Random sweep on DEPTH=5 and DEPTH=4, same stimulus to both.
        m5_cnt = 0; m5_tp = 0; m5_hp = 0;
        m4_cnt = 0; m4_tp = 0; m4_hp = 0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            logic p, o;
            int w5, r5, w4, r4;
            p = ($urandom_range(0, 3) != 0);
            o = (cyc >= 12) ? ($urandom_range(0, 1) == 0) : ($urandom_range(0, 4) == 0);
            if5.push = p; if5.pop = o;
            if4.push = p; if4.pop = o;
            #2;
            w5 = int'(if5.wr_ok); r5 = int'(if5.rd_ok);
            w4 = int'(if4.wr_ok); r4 = int'(if4.rd_ok);
            @(posedge clk); #1;
            sweep_one("d5", 5, p, o, w5, r5, m5_cnt, m5_tp, m5_hp);
            sweep_one("d4", 4, p, o, w4, r4, m4_cnt, m4_tp, m4_hp);
            chk("d5 count", int'(if5.count), m5_cnt);
            chk("d5 full", int'(if5.full), int'(m5_cnt == 5));
            chk("d5 empty", int'(if5.empty), int'(m5_cnt == 0));
            chk("d5 almost_full", int'(if5.almost_full), int'(m5_cnt >= 4));
            chk("d5 almost_empty", int'(if5.almost_empty), int'(m5_cnt <= 1));
            chk("d5 tail_ptr", int'(if5.tail_ptr), m5_tp);
            chk("d5 head_ptr", int'(if5.head_ptr), m5_hp);
            chk("d4 count", int'(if4.count), m4_cnt);
            chk("d4 full", int'(if4.full), int'(m4_cnt == 4));
            chk("d4 empty", int'(if4.empty), int'(m4_cnt == 0));
            chk("d4 almost_full", int'(if4.almost_full), int'(m4_cnt >= 4));
            chk("d4 almost_empty", int'(if4.almost_empty), int'(m4_cnt <= 1));
            chk("d4 tail_ptr", int'(if4.tail_ptr), m4_tp);
            chk("d4 head_ptr", int'(if4.head_ptr), m4_hp);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
